// File: rtl/i2c_cfg_sequencer.sv
// Power-up register loader: walks an external (sub_address, data) ROM and issues one
// single-byte I2C write per entry. Define I2C_CFG_READBACK_EN to verify each write by readback.
module i2c_cfg_sequencer #(
  parameter logic [6:0] DEV_ADDR       = 7'h20,
  parameter int         NUM_REGS       = 16,
  parameter int         POWERUP_CYCLES = 500000,
  parameter int         GAP_CYCLES     = 256,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  tbl_idx,
  input  logic [15:0] tbl_data,
  output logic        request,
  output logic        WR,
  output logic [7:0]  length,
  output logic [6:0]  address,
  output logic [7:0]  sub_address,
  output logic [7:0]  txReg,
  input  logic        busy,
  input  logic        DE,
  input  logic [7:0]  rxReg,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [7:0]  err_count
);

  localparam int MAX_A = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
  localparam int MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] PWR_LIM  = CW'(POWERUP_CYCLES);
  localparam logic [CW-1:0] GAP_LIM  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    LAST_IDX = 8'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    PWR_WAIT, FETCH, LATCH, REQ, WAIT_HI, WAIT_LO, GAP, DONE, ERROR
`ifdef I2C_CFG_READBACK_EN
    , RB_REQ, RB_WAIT_HI, RB_WAIT_LO, RB_CHECK
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_inc;
  logic [7:0]    idx;
  logic [1:0]    busy_sync;
  logic          busy_s;
  logic          restart;

  assign busy_s  = busy_sync[1];
  assign cnt_inc = cnt + CW'(1);
  assign restart = ((state == DONE) || (state == ERROR)) && start;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) busy_sync <= 2'b00;
    else     busy_sync <= {busy_sync[0], busy};
  end

  // cnt is shared: power-up wait, gap, and the wait-state watchdog; it restarts on every state change
  always_comb begin
    state_nxt = state;
    case (state)
      PWR_WAIT: if (cnt_inc == PWR_LIM) state_nxt = FETCH;
      FETCH:    state_nxt = LATCH;
      LATCH:    state_nxt = REQ;
      REQ:      state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (busy_s)                 state_nxt = WAIT_LO;
        else if (cnt_inc == TO_LIM) state_nxt = ERROR;
      end
      WAIT_LO: begin
`ifdef I2C_CFG_READBACK_EN
        if (!busy_s)                state_nxt = RB_REQ;
`else
        if (!busy_s)                state_nxt = GAP;
`endif
        else if (cnt_inc == TO_LIM) state_nxt = ERROR;
      end
      GAP: if (cnt_inc == GAP_LIM) state_nxt = (idx == LAST_IDX) ? DONE : FETCH;
      DONE:  if (start) state_nxt = FETCH;
      ERROR: if (start) state_nxt = FETCH;
`ifdef I2C_CFG_READBACK_EN
      RB_REQ: state_nxt = RB_WAIT_HI;
      RB_WAIT_HI: begin
        if (busy_s)                 state_nxt = RB_WAIT_LO;
        else if (cnt_inc == TO_LIM) state_nxt = ERROR;
      end
      RB_WAIT_LO: begin
        if (!busy_s)                state_nxt = RB_CHECK;
        else if (cnt_inc == TO_LIM) state_nxt = ERROR;
      end
      RB_CHECK: state_nxt = GAP;
`endif
      default: state_nxt = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state       <= PWR_WAIT;
      cnt         <= '0;
      idx         <= 8'd0;
      sub_address <= 8'd0;
      txReg       <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)                  cnt <= '0;
      else if (state != DONE && state != ERROR) cnt <= cnt_inc;
      if (state == LATCH) {sub_address, txReg} <= tbl_data;
      if (restart)                                idx <= 8'd0;
      else if (state == GAP && state_nxt == FETCH) idx <= idx + 8'd1;
    end
  end

  assign tbl_idx   = idx;
  assign length    = 8'd1;
  assign address   = DEV_ADDR;
  assign cfg_done  = (state == DONE);
  assign cfg_error = (state == ERROR);

`ifdef I2C_CFG_READBACK_EN
  logic [1:0] de_sync;
  logic       de_q;
  logic       rb_got;
  logic [7:0] rb_byte;

  assign request = (state == REQ) || (state == WAIT_HI) ||
                   (state == RB_REQ) || (state == RB_WAIT_HI);
  assign WR      = !((state == RB_REQ) || (state == RB_WAIT_HI) || (state == RB_WAIT_LO));

  // only the first byte-done edge of a readback is kept
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      de_sync   <= 2'b00;
      de_q      <= 1'b0;
      rb_got    <= 1'b0;
      rb_byte   <= 8'd0;
      err_count <= 8'd0;
    end else begin
      de_sync <= {de_sync[0], DE};
      de_q    <= de_sync[1];
      if (state == RB_REQ) rb_got <= 1'b0;
      else if (state == RB_WAIT_LO && de_sync[1] && !de_q && !rb_got) begin
        rb_got  <= 1'b1;
        rb_byte <= rxReg;
      end
      if (restart) err_count <= 8'd0;
      else if (state == RB_CHECK && rb_byte != txReg && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end
`else
  logic unused_rb;
  assign unused_rb = &{1'b0, DE, rxReg};
  assign request   = (state == REQ) || (state == WAIT_HI);
  assign WR        = 1'b1;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: random ROM tables and master timing, a request scoreboard,
// and checks of power-up, gap, restart, timeout and mid-transfer reset behaviour.
module tb_i2c_cfg_sequencer;
  localparam int         NREG = 4;
  localparam int         PWR  = 100;
  localparam int         GAPC = 10;
  localparam int         TO   = 300;
  localparam logic [6:0] DEV  = 7'h20;
`ifdef I2C_CFG_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic        clk_50, rst, start, busy, DE;
  logic [7:0]  tbl_idx, length, sub_address, txReg, rxReg, err_count;
  logic [15:0] tbl_data;
  logic [6:0]  address;
  logic        request, WR, cfg_done, cfg_error;

  i2c_cfg_sequencer #(.DEV_ADDR(DEV), .NUM_REGS(NREG), .POWERUP_CYCLES(PWR),
                      .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TO)) dut (
    .clk_50(clk_50), .rst(rst), .start(start), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
    .request(request), .WR(WR), .length(length), .address(address),
    .sub_address(sub_address), .txReg(txReg), .busy(busy), .DE(DE), .rxReg(rxReg),
    .cfg_done(cfg_done), .cfg_error(cfg_error), .err_count(err_count));

  // clock / reset
  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  int cyc = 0;
  initial forever begin @(posedge clk_50); cyc++; end

  // external ROM and readback memory
  logic [15:0] rom [NREG];
  logic [7:0]  rb_mem [256];
  always @(posedge clk_50) tbl_data <= rom[tbl_idx[1:0]];

  int n_vec = 0, n_fail = 0;
  logic [23:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // reference model: one write (plus one readback) per table entry, in table order
  task automatic push_seq();
    for (int i = 0; i < NREG; i++) begin
      exp_q.push_back({DEV, 1'b1, rom[i]});
      if (RB != 0) exp_q.push_back({DEV, 1'b0, rom[i]});
    end
  endtask

  function automatic int exp_errs();
    int e = 0;
    if (RB != 0)
      for (int i = 0; i < NREG; i++)
        if (rb_mem[rom[i][15:8]] != rom[i][7:0]) e++;
    return (e > 255) ? 255 : e;
  endfunction

  // master model
  bit dead = 0;
  int last_drop = 0;
  initial begin
    busy = 1'b0; DE = 1'b0; rxReg = 8'd0;
    forever begin
      @(posedge clk_50); #1;
      if (request && !dead && !rst) begin
        automatic bit         rd   = !WR;
        automatic logic [7:0] sa   = sub_address;
        automatic int         hold = $urandom_range(20, 80);
        repeat ($urandom_range(1, 15)) @(posedge clk_50);
        #1 busy = 1'b1;
        for (int k = 0; k < hold; k++) begin
          @(posedge clk_50); #1;
          if (rd && k == 8)  begin rxReg = rb_mem[sa]; DE = 1'b1; end
          if (rd && k == 11) DE = 1'b0;
        end
        busy = 1'b0;
        last_drop = cyc;
      end
    end
  end

  // scoreboard monitor: every rising request is one transaction
  logic req_q = 1'b0;
  initial forever begin
    @(negedge clk_50);
    if (rst) req_q = 1'b0;
    else begin
      if (request && !req_q) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_request: got sub=0x%0h tx=0x%0h, expected none", sub_address, txReg);
        end else chk("request_fields", {8'd0, address, WR, sub_address, txReg}, {8'd0, exp_q.pop_front()});
      end
      req_q = request;
    end
  end

  // gap monitor: busy release to next entry index = 2 sync + 1 detect (+1 check) + GAPC
  logic [7:0] idx_q = 8'd0;
  initial forever begin
    @(negedge clk_50);
    if (!rst && tbl_idx == idx_q + 8'd1) chk("gap_cycles", cyc - last_drop, 3 + RB + GAPC);
    idx_q = tbl_idx;
  end

  // driver tasks
  task automatic reset_checks();
    chk("rst_request", request, 0);
    chk("rst_WR", WR, 1);
    chk("rst_length", length, 1);
    chk("rst_address", address, DEV);
    chk("rst_sub_address", sub_address, 0);
    chk("rst_txReg", txReg, 0);
    chk("rst_tbl_idx", tbl_idx, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_cfg_error", cfg_error, 0);
    chk("rst_err_count", err_count, 0);
  endtask

  task automatic release_and_measure();
    int n = 0;
    rst = 1'b0;
    while (!request && n < 5 * PWR) begin @(posedge clk_50); #1; n++; end
    chk("powerup_latency", n, PWR + 2);
  endtask

  task automatic pulse_start_and_measure();
    int n = 0;
    start = 1'b1;
    do begin
      @(posedge clk_50); #1;
      start = 1'b0;
      n++;
      if (n == 1) begin
        chk("restart_cfg_done_clr", cfg_done, 0);
        chk("restart_cfg_error_clr", cfg_error, 0);
        chk("restart_err_count_clr", err_count, 0);
      end
    end while (!request && n < 50);
    chk("restart_latency", n, 3);
  endtask

  task automatic wait_req_idx(input logic [7:0] idx);
    int n = 0;
    while (!(request && tbl_idx == idx) && n < 5000) begin @(posedge clk_50); #1; n++; end
    if (n >= 5000) expire("wait_request_entry");
  endtask

  task automatic wait_done_and_check();
    int n = 0;
    while (!cfg_done && !cfg_error && n < 20000) begin @(posedge clk_50); #1; n++; end
    if (n >= 20000) expire("wait_cfg_done");
    chk("done_cfg_done", cfg_done, 1);
    chk("done_cfg_error", cfg_error, 0);
    chk("done_err_count", err_count, exp_errs());
    chk("done_queue_empty", exp_q.size(), 0);
    chk("done_tbl_idx", tbl_idx, NREG - 1);
  endtask

  task automatic randomize_table();
    for (int i = 0; i < NREG; i++) begin
      rom[i] = 16'($urandom);
      rb_mem[rom[i][15:8]] = ($urandom_range(0, 1) != 0) ? rom[i][7:0] : 8'($urandom);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 256; i++) rb_mem[i] = 8'($urandom);
    rom[0] = 16'h0F00; rom[1] = 16'h0180; rom[2] = 16'h3A16;
    rom[3] = {8'($urandom_range(8'h40, 8'hFF)), 8'($urandom)};
    rb_mem[8'h0F] = 8'h00; rb_mem[8'h01] = 8'h80; rb_mem[8'h3A] = 8'hFF;
    rb_mem[rom[3][15:8]] = rom[3][7:0];
    repeat (3) @(posedge clk_50);
    #1 reset_checks();

    // power-up sequence with the reference table
    push_seq();
    release_and_measure();
    wait_done_and_check();

    // restart from DONE, with an ignored start during entry 1
    randomize_table();
    push_seq();
    pulse_start_and_measure();
    wait_req_idx(8'd1);
    start = 1'b1;
    @(posedge clk_50); #1 start = 1'b0;
    wait_done_and_check();

    // dead master: watchdog timeout on entry 0, then recovery by start
    dead = 1;
    push_seq();
    pulse_start_and_measure();
    begin
      automatic int m = 0;
      while (!cfg_error && m < 4 * TO) begin @(posedge clk_50); #1; m++; end
      chk("timeout_cycles", m, TO + 1);
    end
    chk("timeout_request", request, 0);
    chk("timeout_tbl_idx", tbl_idx, 0);
    chk("timeout_cfg_done", cfg_done, 0);
    repeat (5) @(posedge clk_50);
    #1 chk("timeout_sticky", cfg_error, 1);
    exp_q.delete();
    dead = 0;
    randomize_table();
    push_seq();
    pulse_start_and_measure();
    wait_done_and_check();

    // reset while waiting for busy to fall on entry 1
    push_seq();
    pulse_start_and_measure();
    wait_req_idx(8'd1);
    begin
      automatic int n = 0;
      while (request && n < 5000) begin @(posedge clk_50); #1; n++; end
      if (n >= 5000) expire("wait_request_low");
    end
    #5 rst = 1'b1;
    #1 reset_checks();
    exp_q.delete();
    repeat (2) @(posedge clk_50);
    #1 push_seq();
    release_and_measure();
    wait_done_and_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
